// File: rtl/multiplier_seq_pkg.sv
// Shared ALU definitions: data width, sequencer state encoding and
// the done/busy handshake common to the multiplier and divider.
package multiplier_seq_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic busy;
        logic done;
    } hs_t;

    // Handshake seen by ALU control once the sequencer sits in state s
    function automatic hs_t hs_of(state_t s);
        hs_t h;
        h.busy = (s != IDLE);
        h.done = (s == DONE);
        return h;
    endfunction

endpackage

// File: rtl/multiplier_seq_if.sv
// Operand/result bundle between ALU control and the sequential
// multiplier, with the start/done handshake.
interface multiplier_seq_if
    import multiplier_seq_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] product_hi;
    logic [WIDTH-1:0] product_lo;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output start, multiplicand, multiplier,
        input  product_hi, product_lo, busy, done, overflow
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output product_hi, product_lo, busy, done, overflow
    );

endinterface

// File: rtl/multiplier_seq_mul_control.sv
// Multiplier sequencer: IDLE/RUN/DONE FSM and iteration counter,
// producing datapath strobes and the registered busy/done handshake.
module mul_control
    import multiplier_seq_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic clk,
    input  logic reset_a,
    input  logic start,
    output logic load,
    output logic step,
    output logic commit,
    output logic busy,
    output logic done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    hs_t           hs;

    assign load   = (state == IDLE) && start;
    assign step   = (state == RUN);
    assign commit = step && (cnt == LAST);
    assign busy   = hs.busy;
    assign done   = hs.done;

    always_ff @(posedge clk) begin
        if (reset_a) begin
            state <= IDLE;
            cnt   <= '0;
            hs    <= hs_of(IDLE);
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= '0;
                        hs    <= hs_of(RUN);
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        hs    <= hs_of(DONE);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    hs    <= hs_of(IDLE);
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    hs    <= hs_of(IDLE);
                end
            endcase
        end
    end

endmodule

// File: rtl/multiplier_seq.sv
// Sequential unsigned shift-and-add multiplier: one partial product
// per clock, 2*WIDTH-bit result with overflow when the high word is set.
module multiplier_seq
    import multiplier_seq_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic clk,
    input  logic reset_a,
    multiplier_seq_if.slave bus
);

    logic load;
    logic step;
    logic commit;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             carry;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;
    logic             ovf;

    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] shifted;

    mul_control #(.WIDTH(WIDTH)) u_ctrl (
        .clk     (clk),
        .reset_a (reset_a),
        .start   (bus.start),
        .load    (load),
        .step    (step),
        .commit  (commit),
        .busy    (bus.busy),
        .done    (bus.done)
    );

    // Add the multiplicand when the multiplier LSB is set, then shift
    always_comb begin
        sum = {carry, acc_hi};
        if (acc_lo[0]) begin
            sum = {carry, acc_hi} + {1'b0, mcand};
        end
        shifted = {sum, acc_lo} >> 1;
    end

    always_ff @(posedge clk) begin
        if (reset_a) begin
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            carry   <= 1'b0;
            prod_hi <= '0;
            prod_lo <= '0;
            ovf     <= 1'b0;
        end else if (load) begin
            mcand  <= bus.multiplicand;
            acc_hi <= '0;
            acc_lo <= bus.multiplier;
            carry  <= 1'b0;
        end else if (step) begin
            carry  <= shifted[2*WIDTH];
            acc_hi <= shifted[2*WIDTH-1:WIDTH];
            acc_lo <= shifted[WIDTH-1:0];
            if (commit) begin
                prod_hi <= shifted[2*WIDTH-1:WIDTH];
                prod_lo <= shifted[WIDTH-1:0];
                ovf     <= |shifted[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign bus.product_hi = prod_hi;
    assign bus.product_lo = prod_lo;
    assign bus.overflow   = ovf;

endmodule
